logic_gate_unit: RTL and testbench



---
 rtl/logic_gate_unit_pkg.sv | 19 +
 rtl/logic_gate_fifo.sv | 64 ++++++
 rtl/logic_gate_unit.sv | 122 ++++++++++++
 tb/tb_logic_gate_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_unit_pkg.sv
// Shared definitions for the logic gate unit.
// Holds the 3-bit operation code width and the op-code constants
// (OP_AND .. OP_NOT). The unit and its bench both import this package.
package logic_gate_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_fifo.sv
// Generic synchronous FIFO, DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push, wr_data   write request and data (ignored while full)
//   pop             read request (ignored while empty)
//   rd_data         head entry, driven to zero while empty
//   full, empty     occupancy flags
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
// Storage is not reset; only pointers and occupancy are.
module logic_gate_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Head is read straight from storage, so there is no path from push
  // inputs to rd_data within a cycle.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/logic_gate_unit.sv
// Registered, parametrised bitwise logic unit.
// Applies one of eight bitwise operations across NUM_IN masked operands
// and queues the result, with the op code that produced it, in a
// DEPTH-entry FIFO behind valid/ready handshakes.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     operand-set handshake
//   in_data               operand k at bits [k*WIDTH +: WIDTH]
//   in_mask               1 = operand k participates
//   op                    operation code, sampled with in_data
//   out_valid/out_ready   result handshake
//   out_data, out_op      FIFO head result and its op code
//   done_count            output handshakes, wrapping modulo 2^CNT_W
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic [OP_W-1:0]         op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [OP_W-1:0]         out_op,
  output logic [CNT_W-1:0]        done_count
);

  localparam int ENTRY_W = WIDTH + OP_W;

  // Skipping a masked operand is the same as folding in the identity of
  // the base operation (ones for AND, zero for OR/XOR), which also gives
  // the required all-masked results for free.
  function automatic logic [WIDTH-1:0] gate_eval(
    input logic [NUM_IN*WIDTH-1:0] data,
    input logic [NUM_IN-1:0]       mask,
    input logic [OP_W-1:0]         op_code
  );
    logic [WIDTH-1:0] and_acc;
    logic [WIDTH-1:0] or_acc;
    logic [WIDTH-1:0] xor_acc;
    logic [WIDTH-1:0] first;
    logic             found;
    logic [WIDTH-1:0] result;
    and_acc = '1;
    or_acc  = '0;
    xor_acc = '0;
    first   = '0;
    found   = 1'b0;
    result  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (mask[k]) begin
        and_acc = and_acc & data[k*WIDTH +: WIDTH];
        or_acc  = or_acc  | data[k*WIDTH +: WIDTH];
        xor_acc = xor_acc ^ data[k*WIDTH +: WIDTH];
        if (!found) begin
          first = data[k*WIDTH +: WIDTH];
          found = 1'b1;
        end
      end
    end
    case (op_e'(op_code))
      OP_AND:  result = and_acc;
      OP_OR:   result = or_acc;
      OP_XOR:  result = xor_acc;
      OP_NAND: result = ~and_acc;
      OP_NOR:  result = ~or_acc;
      OP_XNOR: result = ~xor_acc;
      OP_PASS: result = first;
      OP_NOT:  result = ~first;
      default: result = '0;
    endcase
    return result;
  endfunction

  logic               accept;
  logic               deliver;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WIDTH-1:0]   result;
  logic [ENTRY_W-1:0] head;

  assign result    = gate_eval(in_data, in_mask, op);
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  logic_gate_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .wr_data ({op, result}),
    .pop     (deliver),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The FIFO drives zero while empty, so both fields read zero then.
  assign out_op   = head[ENTRY_W-1 -: OP_W];
  assign out_data = head[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
    end else if (deliver) begin
      done_count <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;
  import logic_gate_unit_pkg::*;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data = '0;
  logic [NUM_IN-1:0]       in_mask = '0;
  logic [2:0]              op = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [WIDTH-1:0]        out_data;
  logic [2:0]              out_op;
  logic [CNT_W-1:0]        done_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] pat [4];
  logic [7:0] exp_v;
  logic [7:0] held;

  always #5 clk = ~clk;

  logic_gate_unit #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .done_count (done_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Two-operand reference written directly from the op-code table.
  function automatic logic [7:0] ref2(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One accept into an empty FIFO with out_ready=1; result must appear
  // right after the accepting edge and be gone after the next.
  task automatic push_expect(input string tag, input logic [31:0] data,
                             input logic [3:0] mask, input logic [2:0] opc,
                             input logic [7:0] exp);
    in_data  = data;
    in_mask  = mask;
    op       = opc;
    in_valid = 1'b1;
    check({tag, " pre_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(out_data), 32'(exp));
    check({tag, " op"}, 32'(out_op), 32'(opc));
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h0F; pat[3] = 8'hF0;

    // Reset state
    do_reset();
    #1;
    check("rst in_ready",   32'(in_ready),   32'd1);
    check("rst out_valid",  32'(out_valid),  32'd0);
    check("rst out_data",   32'(out_data),   32'd0);
    check("rst out_op",     32'(out_op),     32'd0);
    check("rst done_count", 32'(done_count), 32'd0);

    // 1. Truth-table sweep, two live operands
    out_ready = 1'b1;
    @(posedge clk); #1;
    push_expect("t1 or_0f_f0",   {16'h0, 8'hF0, 8'h0F}, 4'b0011, 3'd1, 8'hFF);
    push_expect("t1 xnor_0f_0f", {16'h0, 8'h0F, 8'h0F}, 4'b0011, 3'd5, 8'hFF);
    push_expect("t1 nand_ff_ff", {16'h0, 8'hFF, 8'hFF}, 4'b0011, 3'd3, 8'h00);
    push_expect("t1 xor_0f_ff",  {16'h0, 8'hFF, 8'h0F}, 4'b0011, 3'd2, 8'hF0);
    push_expect("t1 not_0f",     {16'h0, 8'hFF, 8'h0F}, 4'b0011, 3'd7, 8'hF0);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int o = 0; o < 8; o++)
          push_expect("t1 sweep", {8'hA5, 8'h3C, pat[b], pat[a]}, 4'b0011, 3'(o),
                      ref2(pat[a], pat[b], 3'(o)));

    // 2. Masking, operands lane0..3 = 01,02,04,08
    push_expect("t2 or_m5",    32'h08040201, 4'b0101, 3'd1, 8'h05);
    push_expect("t2 and_m5",   32'h08040201, 4'b0101, 3'd0, 8'h00);
    push_expect("t2 pass_m5",  32'h08040201, 4'b0101, 3'd6, 8'h01);
    push_expect("t2 xor_m5",   32'h08040201, 4'b0101, 3'd2, 8'h05);
    push_expect("t2 pass_ma",  32'h08040201, 4'b1010, 3'd6, 8'h02);
    push_expect("t2 and_m0",   32'h08040201, 4'b0000, 3'd0, 8'hFF);
    push_expect("t2 or_m0",    32'h08040201, 4'b0000, 3'd1, 8'h00);
    push_expect("t2 nor_m0",   32'h08040201, 4'b0000, 3'd4, 8'hFF);
    push_expect("t2 not_m0",   32'h08040201, 4'b0000, 3'd7, 8'hFF);
    push_expect("t2 pass_m0",  32'h08040201, 4'b0000, 3'd6, 8'h00);
    push_expect("t2 nand_m0",  32'h08040201, 4'b0000, 3'd3, 8'h00);

    // 3. Backpressure: A=OR->0x33, B=AND->0x01, C rejected
    do_reset();
    in_valid = 1'b1; in_mask = 4'b0011; op = 3'd1; in_data = {16'h0, 8'h30, 8'h03};
    @(posedge clk); #1;
    check("t3 ready_after1", 32'(in_ready), 32'd1);
    op = 3'd0; in_data = {16'h0, 8'h0F, 8'h11};
    @(posedge clk); #1;
    check("t3 ready_after2", 32'(in_ready), 32'd0);
    op = 3'd2; in_data = {16'h0, 8'hAA, 8'h55};
    @(posedge clk); #1;
    check("t3 ready_held",   32'(in_ready), 32'd0);
    check("t3 head_a",       32'(out_data), 32'h33);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t3 hold_stable", 32'(out_data), 32'(held));
      check("t3 hold_op",     32'(out_op),   32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3 drain_b",     32'(out_data),  32'h01);
    check("t3 drain_b_op",  32'(out_op),    32'd0);
    check("t3 ready_back",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    check("t3 drained",     32'(out_valid), 32'd0);
    check("t3 done_count",  32'(done_count), 32'd2);

    // 4. Full throughput for 20 cycles
    do_reset();
    out_ready = 1'b1;
    in_mask   = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = {8'hA5, 8'h5A, 8'hC3, 8'(i * 7 + 3)};
      op       = (i % 2 == 1) ? 3'd7 : 3'd6;
      exp_v    = (i % 2 == 1) ? ~8'(i * 7 + 3) : 8'(i * 7 + 3);
      @(posedge clk); #1;
      check("t4 valid",    32'(out_valid), 32'd1);
      check("t4 data",     32'(out_data),  32'(exp_v));
      check("t4 in_ready", 32'(in_ready),  32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t4 done_count", 32'(done_count), 32'(19 % 16));

    // 5. Counter wrap at CNT_W=4 after 17 handshakes
    do_reset();
    out_ready = 1'b1;
    in_mask = 4'b1111; op = 3'd1; in_data = 32'h01020408;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 16) check("t5 count_16", 32'(done_count), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t5 wrap", 32'(done_count), 32'd1);

    // 6. Asynchronous reset with the FIFO holding two results
    do_reset();
    in_valid = 1'b1; in_mask = 4'b0001; op = 3'd6; in_data = 32'h000000A1;
    @(posedge clk); #1;
    in_data = 32'h000000B2;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h000000C3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t6 pre_full",  32'(in_ready),   32'd0);
    check("t6 pre_valid", 32'(out_valid),  32'd1);
    check("t6 pre_count", 32'(done_count), 32'd1);
    @(negedge clk); #2;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6 rst_valid", 32'(out_valid),  32'd0);
    check("t6 rst_count", 32'(done_count), 32'd0);
    check("t6 rst_ready", 32'(in_ready),   32'd1);
    check("t6 rst_data",  32'(out_data),   32'd0);
    @(posedge clk); #1;
    check("t6 rst_hold_count", 32'(done_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mask = 4'b0011; op = 3'd2; in_data = {16'h0, 8'h0F, 8'h3C};
    #1;
    check("t6 new_pre", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t6 new_valid", 32'(out_valid), 32'd1);
    check("t6 new_data",  32'(out_data),  32'h33);
    check("t6 new_op",    32'(out_op),    32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
